// File: rtl/gpr_pkg.sv
// gpr_pkg: shared widths, special register numbers and the write-back entry layout
package gpr_pkg;
    localparam int AW = 5;
    localparam int DW = 32;
    localparam logic [AW-1:0] REG_ZERO = 5'd0;
    localparam logic [AW-1:0] REG_OVF  = 5'd30;

    typedef struct packed {
        logic [AW-1:0] dst;
        logic [DW-1:0] data;
        logic          ovf;
    } wb_entry_t;
endpackage

// File: rtl/wb_fifo_2w1r.sv
// wb_fifo_2w1r: circular buffer with two ordered write ports, one read port and explicit occupancy
module wb_fifo_2w1r #(
    parameter int DEPTH = 4,
    parameter int W     = 38
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   flush_i,
    input  logic                   push0_i,
    input  logic [W-1:0]           d0_i,
    input  logic                   push1_i,
    input  logic [W-1:0]           d1_i,
    input  logic                   pop_i,
    output logic [W-1:0]           head_o,
    output logic [W-1:0]           mem_o [DEPTH],
    output logic [DEPTH-1:0]       valid_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [W-1:0]     mem_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_q, rd_d, wr_q, wr_d, wr1;
    logic [CW-1:0]    count_q, count_d;

    // Port 1 lands behind port 0 when both write, otherwise at the write pointer itself
    assign wr1     = wr_q + PW'(push0_i);
    assign head_o  = mem_q[rd_q];
    assign mem_o   = mem_q;
    assign valid_o = valid_q;
    assign count_o = count_q;

    // Next-state of pointers, occupancy and valid bits; flush empties everything
    always_comb begin
        valid_d = valid_q;
        if (pop_i) valid_d[rd_q] = 1'b0;
        if (push0_i) valid_d[wr_q] = 1'b1;
        if (push1_i) valid_d[wr1] = 1'b1;
        if (flush_i) valid_d = '0;
        rd_d    = flush_i ? '0 : rd_q + PW'(pop_i);
        wr_d    = flush_i ? '0 : wr_q + PW'(push0_i) + PW'(push1_i);
        count_d = flush_i ? '0 : count_q + CW'(push0_i) + CW'(push1_i) - CW'(pop_i);
    end

    // Control state with synchronous active-low reset
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            valid_q <= '0;
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else begin
            valid_q <= valid_d;
            rd_q    <= rd_d;
            wr_q    <= wr_d;
            count_q <= count_d;
        end
    end

    // Payload storage; slots written under flush/reset stay invalid so need no reset
    always_ff @(posedge clk_i) begin
        if (push0_i) mem_q[wr_q] <= d0_i;
        if (push1_i) mem_q[wr1] <= d1_i;
    end
endmodule

// File: rtl/gpr_wb_queue.sv
// gpr_wb_queue: merges ALU and load write-backs into one ordered queue feeding the GPR write port
module gpr_wb_queue
    import gpr_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                   clk_i,
    input  logic                   reset_ni,
    input  logic                   a_valid_i,
    output logic                   a_ready_o,
    input  logic [AW-1:0]          a_reg_i,
    input  logic [DW-1:0]          a_data_i,
    input  logic                   a_ovf_i,
    input  logic                   m_valid_i,
    output logic                   m_ready_o,
    input  logic [AW-1:0]          m_reg_i,
    input  logic [DW-1:0]          m_data_i,
    input  logic                   wb_stall_i,
    input  logic                   flush_i,
    output logic                   reg_write_o,
    output logic [AW-1:0]          write_reg_o,
    output logic [DW-1:0]          write_data_o,
    output logic                   overflow_o,
    output logic [31:0]            busy_mask_o,
    output logic [$clog2(DEPTH):0] count_o
);
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int W  = $bits(wb_entry_t);

    wb_entry_t        a_ent, m_ent, head;
    logic [W-1:0]     head_raw;
    logic [W-1:0]     mem [DEPTH];
    logic [DEPTH-1:0] valid;
    logic             a_push, m_push, pop, empty;

    // Ready looks only at current occupancy: a same-cycle drain never frees a slot
    assign empty     = count_o == '0;
    assign a_ready_o = count_o < CW'(DEPTH);
    assign m_ready_o = (count_o < CW'(DEPTH - 1)) || (a_ready_o && !a_valid_i);
    // Writes to r0 are swallowed unless they carry an overflow that must reach the GPR
    assign a_push    = a_valid_i && a_ready_o && (a_reg_i != REG_ZERO || a_ovf_i);
    assign m_push    = m_valid_i && m_ready_o && m_reg_i != REG_ZERO;
    assign a_ent     = '{dst: a_reg_i, data: a_data_i, ovf: a_ovf_i};
    assign m_ent     = '{dst: m_reg_i, data: m_data_i, ovf: 1'b0};
    assign pop       = !empty && !wb_stall_i;
    assign head      = empty ? '0 : wb_entry_t'(head_raw);

    assign reg_write_o  = pop;
    assign write_reg_o  = head.dst;
    assign write_data_o = head.data;
    assign overflow_o   = head.ovf;

    wb_fifo_2w1r #(.DEPTH(DEPTH), .W(W)) u_fifo (
        .clk_i   (clk_i),
        .reset_ni(reset_ni),
        .flush_i (flush_i),
        .push0_i (a_push),
        .d0_i    (a_ent),
        .push1_i (m_push),
        .d1_i    (m_ent),
        .pop_i   (pop),
        .head_o  (head_raw),
        .mem_o   (mem),
        .valid_o (valid),
        .count_o (count_o)
    );

    // Pending-write scoreboard: one bit per destination held by any valid entry
    always_comb begin
        busy_mask_o = '0;
        for (int i = 0; i < DEPTH; i++)
            busy_mask_o = busy_mask_o | ({32{valid[i]}} & (32'd1 << mem[i][W-1 -: AW]));
    end
endmodule

// File: tb/tb_gpr_wb_queue.sv
// tb_gpr_wb_queue: directed and random checks of the write-back queue against a queue-based model
module tb_gpr_wb_queue;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n, a_valid, a_ovf, m_valid, wb_stall, flush;
    logic [4:0]  a_reg, m_reg, write_reg;
    logic [31:0] a_data, m_data, write_data, busy;
    logic        a_ready, m_ready, reg_write, ovf;
    logic [2:0]  count;
    int          tests = 0;
    int          fails = 0;

    typedef struct {
        logic [4:0]  r;
        logic [31:0] d;
        logic        o;
    } ent_t;
    ent_t q[$];

    gpr_wb_queue #(.DEPTH(4)) dut (
        .clk_i(clk), .reset_ni(reset_n),
        .a_valid_i(a_valid), .a_ready_o(a_ready), .a_reg_i(a_reg), .a_data_i(a_data), .a_ovf_i(a_ovf),
        .m_valid_i(m_valid), .m_ready_o(m_ready), .m_reg_i(m_reg), .m_data_i(m_data),
        .wb_stall_i(wb_stall), .flush_i(flush),
        .reg_write_o(reg_write), .write_reg_o(write_reg), .write_data_o(write_data),
        .overflow_o(ovf), .busy_mask_o(busy), .count_o(count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_model();
        int          sz;
        logic [31:0] eb;
        sz = q.size();
        eb = 0;
        foreach (q[i]) eb[q[i].r] = 1'b1;
        chk("count", 32'(count), 32'(sz));
        chk("a_ready", 32'(a_ready), 32'(sz < 4));
        chk("m_ready", 32'(m_ready), 32'((sz < 3) || (sz < 4 && !a_valid)));
        chk("reg_write", 32'(reg_write), 32'(sz > 0 && !wb_stall));
        chk("write_reg", 32'(write_reg), sz > 0 ? 32'(q[0].r) : 32'd0);
        chk("write_data", write_data, sz > 0 ? q[0].d : 32'd0);
        chk("overflow", 32'(ovf), sz > 0 ? 32'(q[0].o) : 32'd0);
        chk("busy_mask", busy, eb);
    endtask

    task automatic drive(input logic rn, input logic av, input logic [4:0] ar, input logic [31:0] ad,
                         input logic ao, input logic mv, input logic [4:0] mr, input logic [31:0] md,
                         input logic st, input logic fl);
        reset_n = rn; a_valid = av; a_reg = ar; a_data = ad; a_ovf = ao;
        m_valid = mv; m_reg = mr; m_data = md; wb_stall = st; flush = fl;
        #4;
        check_model();
    endtask

    task automatic idle(input logic st);
        drive(1, 0, 0, 0, 0, 0, 0, 0, st, 0);
    endtask

    task automatic tick();
        int   sz;
        logic ar_ok, mr_ok, pop;
        sz    = q.size();
        ar_ok = sz < 4;
        mr_ok = (sz < 3) || (sz < 4 && !a_valid);
        pop   = sz > 0 && !wb_stall;
        @(posedge clk);
        if (!reset_n) q.delete();
        else begin
            if (pop) void'(q.pop_front());
            if (flush) q.delete();
            else begin
                if (a_valid && ar_ok && (a_reg != 0 || a_ovf)) q.push_back('{a_reg, a_data, a_ovf});
                if (m_valid && mr_ok && m_reg != 0) q.push_back('{m_reg, m_data, 1'b0});
            end
        end
        #1;
    endtask

    initial begin
        reset_n = 0; a_valid = 0; a_reg = 0; a_data = 0; a_ovf = 0;
        m_valid = 0; m_reg = 0; m_data = 0; wb_stall = 0; flush = 0;
        repeat (2) @(posedge clk);
        #1;
        idle(0);
        chk("rst_a_ready", 32'(a_ready), 1);
        chk("rst_m_ready", 32'(m_ready), 1);
        tick();
        // single ALU write
        drive(1, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 0); tick();
        idle(0);
        chk("t1_regwrite", 32'(reg_write), 1);
        chk("t1_reg", 32'(write_reg), 5);
        chk("t1_data", write_data, 32'h1234);
        chk("t1_busy", busy, 32'h20);
        tick();
        idle(0);
        chk("t1_count", 32'(count), 0);
        chk("t1_busy0", busy, 0);
        tick();
        // both ports in one cycle: ALU older
        drive(1, 1, 3, 32'hAAAA, 0, 1, 4, 32'hBBBB, 0, 0); tick();
        idle(0); chk("t2_first", 32'(write_reg), 3); chk("t2_busy", busy, 32'h18); tick();
        idle(0); chk("t2_second", 32'(write_reg), 4); chk("t2_data", write_data, 32'hBBBB); tick();
        // stalled fill up to full
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(6 + i), 32'(i), 0, 0, 0, 0, 1, 0); tick();
        end
        drive(1, 1, 9, 32'h90, 0, 1, 10, 32'hA0, 1, 0);
        chk("t3_a_ready3", 32'(a_ready), 1);
        chk("t3_m_ready3", 32'(m_ready), 0);
        tick();
        drive(1, 1, 11, 32'hB0, 0, 0, 0, 0, 1, 0);
        chk("t3_full_ready", 32'(a_ready), 0);
        chk("t3_full_count", 32'(count), 4);
        chk("t3_held_head", 32'(write_reg), 6);
        tick();
        repeat (5) begin idle(0); tick(); end
        // r0 drop rule and overflow entry
        drive(1, 1, 0, 32'hDEAD, 0, 0, 0, 0, 0, 0); tick();
        idle(0); chk("t4_drop_count", 32'(count), 0); chk("t4_drop_rw", 32'(reg_write), 0); tick();
        drive(1, 1, 0, 32'hBEEF, 1, 0, 0, 0, 0, 0); tick();
        idle(0);
        chk("t4_ovf_rw", 32'(reg_write), 1);
        chk("t4_ovf", 32'(ovf), 1);
        chk("t4_ovf_busy", busy, 32'h1);
        tick();
        // flush with a same-edge push
        for (int i = 0; i < 3; i++) begin
            drive(1, 1, 5'(12 + i), 32'(i), 0, 0, 0, 0, 1, 0); tick();
        end
        drive(1, 1, 15, 32'hF, 0, 0, 0, 0, 0, 1);
        chk("t5_issue", 32'(reg_write), 1);
        chk("t5_head", 32'(write_reg), 12);
        tick();
        idle(0); chk("t5_count", 32'(count), 0); chk("t5_busy", busy, 0); tick();
        // reset wins over a same-edge push
        for (int i = 0; i < 2; i++) begin
            drive(1, 1, 5'(20 + i), 32'(i), 0, 0, 0, 0, 1, 0); tick();
        end
        drive(0, 1, 17, 32'h17, 0, 1, 18, 32'h18, 0, 0); tick();
        idle(0);
        chk("t6_count", 32'(count), 0);
        chk("t6_busy", busy, 0);
        chk("t6_rw", 32'(reg_write), 0);
        chk("t6_m_ready", 32'(m_ready), 1);
        tick();
        // randomized traffic
        for (int n = 0; n < 500; n++) begin
            drive($urandom_range(0, 59) != 0, 1'($urandom), ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom),
                  $urandom, $urandom_range(0, 7) == 0, 1'($urandom),
                  ($urandom_range(0, 5) == 0) ? 5'd0 : 5'($urandom), $urandom,
                  $urandom_range(0, 2) == 0, $urandom_range(0, 24) == 0);
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
